// File: rtl/pin_entry_display_pkg.sv
`default_nettype none
// ============================================================================
// Module  : door_pkg
// Brief   : Shared types, key codes and display glyphs for the door-lock PIN path
// Revision: 1.0  initial release
// ============================================================================
package door_pkg;

  // Six BCD nibbles, index 0 is the rightmost / newest digit
  typedef logic [5:0][3:0] bcdPac_t;

  localparam logic [3:0] KEY_BACKSPACE = 4'hA;
  localparam logic [3:0] KEY_SUBMIT    = 4'hB;
  localparam logic [3:0] KEY_CLEAR     = 4'hC;

  localparam logic [3:0] GLYPH_BLANK = 4'hF;
  localparam logic [3:0] GLYPH_MASK  = 4'hA;

  localparam bcdPac_t BCD_ALL_BLANK = {6{GLYPH_BLANK}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } entry_state_t;

  // Unused positions blank, older digits masked, newest shown only while revealed
  function automatic bcdPac_t display_map(bcdPac_t digits, logic [2:0] len, logic reveal);
    bcdPac_t m;
    m = BCD_ALL_BLANK;
    for (int i = 0; i < 6; i++) begin
      if (3'(i) >= len) begin
        m[i] = GLYPH_BLANK;
      end else if ((i == 0) && reveal) begin
        m[i] = digits[i];
      end else begin
        m[i] = GLYPH_MASK;
      end
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pin_entry_display_if.sv
`default_nettype none
// ============================================================================
// Module  : pin_entry_display_if
// Brief   : Keypad-in / display-and-PIN-out bundle of the PIN entry block
// Revision: 1.0  initial release
// ============================================================================
interface pin_entry_display_if;
  import door_pkg::*;

  logic        key_valid;
  logic [3:0]  key_code;
  bcdPac_t     bcd_packet;
  logic        disp_enable;
  logic        pin_valid;
  bcdPac_t     pin_code;
  logic [2:0]  pin_len;
  logic        pin_reject;
  logic        timeout;
  logic        entry_active;

  modport master (
    output key_valid, key_code,
    input  bcd_packet, disp_enable, pin_valid, pin_code, pin_len,
           pin_reject, timeout, entry_active
  );

  modport slave (
    input  key_valid, key_code,
    output bcd_packet, disp_enable, pin_valid, pin_code, pin_len,
           pin_reject, timeout, entry_active
  );

endinterface
`default_nettype wire

// File: rtl/pin_entry_display_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module  : cycle_timer
// Brief   : Saturating cycle counter with restart and expiry flag
// Revision: 1.0  initial release
// ============================================================================
module cycle_timer #(
  parameter int LIMIT = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic restart,
  output logic      expired
);

  localparam int                 c_width = $clog2(LIMIT + 1);
  localparam logic [c_width-1:0] c_limit = c_width'(LIMIT);

  logic [c_width-1:0] r_count;
  logic [c_width-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (restart) begin
      w_count_next = '0;
    end else if (r_count != c_limit) begin
      w_count_next = r_count + c_width'(1);
    end
  end

  // Flag reflects the count as it will stand after this edge, so registered
  // consumers in the parent line up with the counter itself.
  assign expired = (w_count_next == c_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pin_entry_display.sv
`default_nettype none
// ============================================================================
// Module  : pin_entry_display
// Brief   : Keypad PIN entry with masked six-digit display, submit and timeout
// Revision: 1.0  initial release
// ============================================================================
module pin_entry_display
  import door_pkg::*;
#(
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int REVEAL_CYCLES  = 25_000_000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pin_entry_display_if.slave bus
);

  entry_state_t r_state;
  entry_state_t w_state_next;
  bcdPac_t      r_digits;
  bcdPac_t      w_digits_next;
  logic [2:0]   r_len;
  logic [2:0]   w_len_next;
  logic         r_show_newest;
  logic         w_show_next;

  logic w_digit_key;
  logic w_push;
  logic w_flush;
  logic w_valid_next;
  logic w_reject_next;
  logic w_timeout_next;
  logic w_idle_restart;
  logic w_idle_expired;
  logic w_reveal_expired;

  assign w_digit_key    = bus.key_valid && (bus.key_code <= 4'd9);
  assign w_idle_restart = (r_state != ENTRY) || bus.key_valid;

  cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (w_idle_restart),
    .expired (w_idle_expired)
  );

  cycle_timer #(.LIMIT(REVEAL_CYCLES)) u_reveal_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (w_push),
    .expired (w_reveal_expired)
  );

  always_comb begin
    w_state_next   = r_state;
    w_digits_next  = r_digits;
    w_len_next     = r_len;
    w_show_next    = r_show_newest;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    w_valid_next   = 1'b0;
    w_reject_next  = 1'b0;
    w_timeout_next = 1'b0;

    case (r_state)
      IDLE: begin
        w_push = w_digit_key;
      end
      ENTRY: begin
        if (bus.key_valid) begin
          if (w_digit_key) begin
            w_push = (r_len < 3'd6);
          end else if (bus.key_code == KEY_BACKSPACE) begin
            w_digits_next = {GLYPH_BLANK, r_digits[5:1]};
            w_len_next    = r_len - 3'd1;
            w_show_next   = 1'b0;
            if (r_len == 3'd1) begin
              w_state_next = IDLE;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            w_flush = 1'b1;
          end else if (bus.key_code == KEY_SUBMIT) begin
            w_flush = 1'b1;
            if (r_len >= 3'(MIN_DIGITS)) begin
              w_valid_next = 1'b1;
            end else begin
              w_reject_next = 1'b1;
            end
          end
        end else if (w_idle_expired) begin
          w_flush        = 1'b1;
          w_timeout_next = 1'b1;
        end
      end
      DONE: begin
        w_flush = 1'b1;
      end
      default: begin
        w_flush = 1'b1;
      end
    endcase

    if (w_flush) begin
      w_digits_next = BCD_ALL_BLANK;
      w_len_next    = 3'd0;
      w_show_next   = 1'b0;
      w_state_next  = w_valid_next ? DONE : IDLE;
    end

    if (w_push) begin
      w_digits_next = {r_digits[4:0], bus.key_code};
      w_len_next    = r_len + 3'd1;
      w_show_next   = 1'b1;
      w_state_next  = ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_digits      <= BCD_ALL_BLANK;
      r_len         <= 3'd0;
      r_show_newest <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_digits      <= w_digits_next;
      r_len         <= w_len_next;
      r_show_newest <= w_show_next;
    end
  end

  // Outputs are computed from next-state values so a key in cycle N shows in N+1
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bcd_packet   <= BCD_ALL_BLANK;
      bus.disp_enable  <= 1'b0;
      bus.pin_valid    <= 1'b0;
      bus.pin_code     <= BCD_ALL_BLANK;
      bus.pin_len      <= 3'd0;
      bus.pin_reject   <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.entry_active <= 1'b0;
    end else begin
      bus.bcd_packet   <= display_map(w_digits_next, w_len_next,
                                      w_show_next && !w_reveal_expired);
      bus.disp_enable  <= 1'b1;
      bus.pin_valid    <= w_valid_next;
      bus.pin_reject   <= w_reject_next;
      bus.timeout      <= w_timeout_next;
      bus.entry_active <= (w_state_next == ENTRY);
      if (w_valid_next) begin
        bus.pin_code <= r_digits;
        bus.pin_len  <= r_len;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pin_entry_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_pin_entry_display
// Brief   : Directed self-checking bench for pin_entry_display
// Revision: 1.0  initial release
// ============================================================================
module tb_pin_entry_display;
  import door_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pin_entry_display_if bus ();

  pin_entry_display #(
    .MIN_DIGITS     (4),
    .TIMEOUT_CYCLES (20),
    .REVEAL_CYCLES  (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses packed as {pin_valid, pin_reject, timeout, entry_active}
  function automatic logic [31:0] flags();
    return {28'd0, bus.pin_valid, bus.pin_reject, bus.timeout, bus.entry_active};
  endfunction

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;

    // Reset state
    idle(2);
    check("rst_bcd",      {8'd0, bus.bcd_packet}, 32'h00FFFFFF);
    check("rst_disp_en",  {31'd0, bus.disp_enable}, 32'd0);
    check("rst_pin_code", {8'd0, bus.pin_code}, 32'h00FFFFFF);
    check("rst_pin_len",  {29'd0, bus.pin_len}, 32'd0);
    check("rst_flags",    flags(), 32'd0);
    rst = 1'b0;
    tick();
    check("disp_en_after_rst", {31'd0, bus.disp_enable}, 32'd1);
    idle(3);
    check("idle_bcd",   {8'd0, bus.bcd_packet}, 32'h00FFFFFF);
    check("idle_flags", flags(), 32'd0);

    // 1,2,3 spaced ten cycles, then reveal expiry of the newest digit
    press(4'd1);
    idle(9);
    press(4'd2);
    idle(9);
    press(4'd3);
    check("reveal_3",      {8'd0, bus.bcd_packet}, 32'h00FFFAA3);
    check("entry_active",  flags(), 32'd1);
    idle(4);
    check("reveal_hold_4", {8'd0, bus.bcd_packet}, 32'h00FFFAA3);
    idle(1);
    check("reveal_mask_5", {8'd0, bus.bcd_packet}, 32'h00FFFAAA);
    press(KEY_CLEAR);
    check("clear_bcd",   {8'd0, bus.bcd_packet}, 32'h00FFFFFF);
    check("clear_flags", flags(), 32'd0);

    // Six digits, seventh ignored, valid submit, key during DONE dropped
    for (int d = 1; d <= 7; d++) press(4'(d));
    check("full_ignore_7", {8'd0, bus.bcd_packet}, 32'h00AAAAA6);
    press(KEY_SUBMIT);
    check("submit_flags",  flags(), 32'h8);
    check("submit_code",   {8'd0, bus.pin_code}, 32'h00123456);
    check("submit_len",    {29'd0, bus.pin_len}, 32'd6);
    check("submit_bcd",    {8'd0, bus.bcd_packet}, 32'h00FFFFFF);
    press(4'd4);
    check("done_drop_flags", flags(), 32'd0);
    check("done_drop_bcd",   {8'd0, bus.bcd_packet}, 32'h00FFFFFF);
    check("pin_code_hold",   {8'd0, bus.pin_code}, 32'h00123456);

    // Exactly MIN_DIGITS accepted
    press(4'd4);
    press(4'd3);
    press(4'd2);
    press(4'd1);
    press(KEY_SUBMIT);
    check("min_flags", flags(), 32'h8);
    check("min_code",  {8'd0, bus.pin_code}, 32'h00FF4321);
    check("min_len",   {29'd0, bus.pin_len}, 32'd4);
    tick();

    // Backspace then short submit
    press(4'd9);
    press(4'd8);
    press(KEY_BACKSPACE);
    check("bksp_bcd",     {8'd0, bus.bcd_packet}, 32'h00FFFFFA);
    press(KEY_SUBMIT);
    check("reject_flags", flags(), 32'h4);
    check("reject_bcd",   {8'd0, bus.bcd_packet}, 32'h00FFFFFF);
    tick();
    check("reject_end",   flags(), 32'd0);
    check("reject_code",  {8'd0, bus.pin_code}, 32'h00FF4321);

    // Inactivity timeout
    press(4'd5);
    press(4'd5);
    idle(19);
    check("pre_timeout", flags(), 32'd1);
    idle(1);
    check("timeout_flags", flags(), 32'h2);
    check("timeout_bcd",   {8'd0, bus.bcd_packet}, 32'h00FFFFFF);
    tick();
    check("timeout_end",   flags(), 32'd0);

    // Key on the expiry cycle wins
    press(4'd5);
    press(4'd5);
    idle(19);
    press(4'd5);
    check("key_wins_flags", flags(), 32'd1);
    check("key_wins_bcd",   {8'd0, bus.bcd_packet}, 32'h00FFFAA5);
    press(KEY_CLEAR);

    // Reset mid-entry, then submit in IDLE ignored
    press(4'd1);
    press(4'd2);
    press(4'd3);
    rst = 1'b1;
    tick();
    check("midrst_bcd",   {8'd0, bus.bcd_packet}, 32'h00FFFFFF);
    check("midrst_flags", flags(), 32'd0);
    check("midrst_code",  {8'd0, bus.pin_code}, 32'h00FFFFFF);
    check("midrst_len",   {29'd0, bus.pin_len}, 32'd0);
    check("midrst_den",   {31'd0, bus.disp_enable}, 32'd0);
    rst = 1'b0;
    tick();
    press(KEY_SUBMIT);
    check("idle_submit_flags", flags(), 32'd0);
    check("idle_submit_bcd",   {8'd0, bus.bcd_packet}, 32'h00FFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
